// File: rtl/sad_min_search.sv
// sad_min_search
//   Running-minimum search over a square motion-estimation window. Accepts one
//   16x16 SAD per search position in raster order (mvx fastest), generates the
//   motion vector of each position from internal counters, and keeps the best
//   (lowest-cost) SAD with its MV. Pulses done for one cycle when the last
//   position (RANGE-1, RANGE-1) has been accepted.
//
//   Optional feature macro: SAD_MVCOST_EN
//     defined   : cost = sad_in + ((|mvx| + |mvy|) << LAMBDA_SHIFT)
//     undefined : cost = sad_in (no abs/shift logic)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous reset, active-low
//   start      in   begin a new window; sampled only in IDLE or DONE
//   sad_valid  in   sad_in holds the SAD of the current position
//   sad_in     in   SAD of the current position, unsigned
//   busy       out  high while searching
//   done       out  one-cycle pulse after the last position is accepted
//   best_sad   out  raw SAD of the winning position
//   best_mvx   out  horizontal MV of the winner, two's complement
//   best_mvy   out  vertical MV of the winner, two's complement
module sad_min_search #(
  parameter int SAD_WIDTH    = 16,
  parameter int RANGE        = 8,
  parameter int MV_WIDTH     = $clog2(RANGE) + 1,
  parameter int LAMBDA_SHIFT = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       sad_valid,
  input  logic [SAD_WIDTH-1:0]       sad_in,
  output logic                       busy,
  output logic                       done,
  output logic [SAD_WIDTH-1:0]       best_sad,
  output logic signed [MV_WIDTH-1:0] best_mvx,
  output logic signed [MV_WIDTH-1:0] best_mvy
);

  // Wide enough that sad_in plus the largest MV penalty never overflows.
  localparam int COST_W = SAD_WIDTH + MV_WIDTH + 2;
  localparam logic signed [MV_WIDTH-1:0] MV_MIN = MV_WIDTH'(-RANGE);
  localparam logic signed [MV_WIDTH-1:0] MV_MAX = MV_WIDTH'(RANGE - 1);
  localparam logic signed [MV_WIDTH-1:0] MV_ONE = MV_WIDTH'(1);

  if (RANGE < 2 || (RANGE & (RANGE - 1)) != 0) begin : g_bad_range
    $error("sad_min_search: RANGE must be a power of two >= 2");
  end
  if (LAMBDA_SHIFT < 0) begin : g_bad_lambda
    $error("sad_min_search: LAMBDA_SHIFT must be non-negative");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_DONE
  } state_t;

  state_t                       state_q, state_d;
  logic signed [MV_WIDTH-1:0]   cur_x_q, cur_x_d;
  logic signed [MV_WIDTH-1:0]   cur_y_q, cur_y_d;
  logic [COST_W-1:0]            best_cost_q, best_cost_d;
  logic [SAD_WIDTH-1:0]         best_sad_q, best_sad_d;
  logic signed [MV_WIDTH-1:0]   best_mvx_q, best_mvx_d;
  logic signed [MV_WIDTH-1:0]   best_mvy_q, best_mvy_d;
  logic [COST_W-1:0]            cost;
  logic                         last_pos;
  logic                         init;

`ifdef SAD_MVCOST_EN
  // |-RANGE| = RANGE still fits once the result is read as unsigned.
  function automatic logic [MV_WIDTH-1:0] mv_abs(input logic signed [MV_WIDTH-1:0] v);
    return v[MV_WIDTH-1] ? MV_WIDTH'(-v) : v;
  endfunction

  always_comb begin
    cost = COST_W'(sad_in)
         + ((COST_W'(mv_abs(cur_x_q)) + COST_W'(mv_abs(cur_y_q))) << LAMBDA_SHIFT);
  end
`else
  always_comb begin
    cost = COST_W'(sad_in);
  end
`endif

  assign last_pos = (cur_x_q == MV_MAX) && (cur_y_q == MV_MAX);

  always_comb begin
    state_d     = state_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    best_cost_d = best_cost_q;
    best_sad_d  = best_sad_q;
    best_mvx_d  = best_mvx_q;
    best_mvy_d  = best_mvy_q;
    init        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          init    = 1'b1;
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (sad_valid) begin
          // Strict compare: on a tie the earlier position is kept.
          if (cost < best_cost_q) begin
            best_cost_d = cost;
            best_sad_d  = sad_in;
            best_mvx_d  = cur_x_q;
            best_mvy_d  = cur_y_q;
          end
          if (cur_x_q == MV_MAX) begin
            cur_x_d = MV_MIN;
            cur_y_d = cur_y_q + MV_ONE;
          end else begin
            cur_x_d = cur_x_q + MV_ONE;
          end
          if (last_pos) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          init    = 1'b1;
          state_d = ST_SEARCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (init) begin
      cur_x_d     = MV_MIN;
      cur_y_d     = MV_MIN;
      best_cost_d = '1;
      best_sad_d  = '1;
      best_mvx_d  = '0;
      best_mvy_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      best_cost_q <= '1;
      best_sad_q  <= '1;
      best_mvx_q  <= '0;
      best_mvy_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      best_cost_q <= best_cost_d;
      best_sad_q  <= best_sad_d;
      best_mvx_q  <= best_mvx_d;
      best_mvy_q  <= best_mvy_d;
    end
  end

  assign busy     = (state_q == ST_SEARCH);
  assign done     = (state_q == ST_DONE);
  assign best_sad = best_sad_q;
  assign best_mvx = best_mvx_q;
  assign best_mvy = best_mvy_q;

endmodule
